gmii_frame_fifo: RTL

GMII_FRAME_FIFO -- requirements
Module: gmii_frame_fifo

---
 rtl/gmii_frame_pkg.sv | 9 +
 rtl/gmii_frame_ram.sv | 21 ++
 rtl/gmii_frame_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/gmii_frame_pkg.sv
// gmii_frame_pkg: shared write-FSM state type and RAM word layout for gmii_frame_fifo.
package gmii_frame_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} wr_state_t;
  // Each RAM word is {last, data}; the last flag sits just above the payload.
  function automatic int last_bit_idx(input int data_w);
    return data_w;
  endfunction
  localparam int LAST_BIT = last_bit_idx(8);
endpackage

// File: rtl/gmii_frame_ram.sv
// gmii_frame_ram: synchronous 1R1W RAM; rdata holds whenever re is low.
module gmii_frame_ram
  import gmii_frame_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/gmii_frame_fifo.sv
// gmii_frame_fifo: GMII receive frame store-and-forward FIFO with AXI-stream-like output.
// Optional GMII_FRAME_STATS_EN adds saturating good/dropped frame counters.
module gmii_frame_fifo
  import gmii_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 64
) (
  input  logic                          clk125,
  input  logic                          aresetn,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_val,
  input  logic                          in_sof,
  input  logic                          in_eof,
  input  logic                          in_err,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(MAX_FRAMES):0]   frames_avail,
  output logic                          drop_pulse
`ifdef GMII_FRAME_STATS_EN
  ,
  output logic [31:0]                   good_frames,
  output logic [31:0]                   dropped_frames
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  localparam int LB = last_bit_idx(DATA_W);

  wr_state_t state, state_nxt;
  logic [PW-1:0] wr_ptr, commit_ptr, frame_start, rd_ptr, base, fs;
  logic err_seen, act, blocked, err_now, we, bad, commit, restart;
  logic re, adv, r_v, pop;
  logic [LB:0] rdata;

  // A sof inside RECV abandons the partial frame, so the new frame is placed at its start.
  always_comb begin
    base      = (state == RECV && in_sof) ? frame_start : wr_ptr;
    act       = in_val && (in_sof ? state != DROP : state == RECV);
    blocked   = (base - rd_ptr) == PW'(DEPTH) || frames_avail == FW'(MAX_FRAMES);
    err_now   = in_err || (err_seen && !in_sof);
    fs        = in_sof ? base : frame_start;
    we        = act && !blocked;
    bad       = act && (blocked || (in_eof && err_now));
    commit    = we && in_eof && !err_now;
    restart   = in_val && in_sof && state == RECV;
    state_nxt = act ? (in_eof ? IDLE : blocked ? DROP : RECV)
              : (state == DROP && in_val && in_eof) ? IDLE : state;
    pop       = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    adv       = r_v && (!m_axis_tvalid || m_axis_tready);
    re        = rd_ptr != commit_ptr && (!r_v || adv);
  end

  always_ff @(posedge clk125 or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      frame_start   <= '0;
      rd_ptr        <= '0;
      err_seen      <= 1'b0;
      r_v           <= 1'b0;
      frames_avail  <= '0;
      drop_pulse    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= (we && !(in_eof && err_now)) ? base + PW'(1) : act ? fs : wr_ptr;
      frame_start  <= (act && in_sof) ? base : frame_start;
      err_seen     <= act ? err_now : err_seen;
      commit_ptr   <= commit ? base + PW'(1) : commit_ptr;
      drop_pulse   <= bad || restart;
      frames_avail <= frames_avail + FW'(commit) - FW'(pop);
      rd_ptr       <= re ? rd_ptr + PW'(1) : rd_ptr;
      r_v          <= re || (r_v && !adv);
      // RAM output only moves into the output register when that register is free.
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tvalid <= r_v;
        m_axis_tdata  <= r_v ? rdata[DATA_W-1:0] : m_axis_tdata;
        m_axis_tlast  <= r_v ? rdata[LB] : m_axis_tlast;
      end
    end
  end

`ifdef GMII_FRAME_STATS_EN
  always_ff @(posedge clk125 or negedge aresetn) begin
    if (!aresetn) begin
      good_frames    <= '0;
      dropped_frames <= '0;
    end else begin
      good_frames    <= (commit && !(&good_frames)) ? good_frames + 32'd1 : good_frames;
      dropped_frames <= (drop_pulse && !(&dropped_frames)) ? dropped_frames + 32'd1 : dropped_frames;
    end
  end
`endif

  gmii_frame_ram #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
    .clk   (clk125),
    .we    (we),
    .waddr (base[AW-1:0]),
    .wdata ({in_eof, in_data}),
    .re    (re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );
endmodule
